// File: rtl/seq_arithmetic.sv
// ---------------------------------------------------------------------------
// SeqArithmetic: sequential unsigned arithmetic unit (add, subtract,
// multiply, and optionally divide).
//
// Add and subtract finish one cycle after start is accepted. Multiply uses
// iterative shift-add, and divide uses restoring division. Each of these
// takes WIDTH iterations in CALC before the FINISH cycle.
//
// Optional feature macro: SEQ_ARITHMETIC_DIV_EN
//   Defined   : op=11 is a restoring divide; result = {remainder, quotient}.
//               Divide by zero gives quotient all-ones, remainder = a, flag = 1.
//   Undefined : op=11 is illegal; it finishes in one cycle with result=0, flag=1.
//
// Ports:
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request to begin an operation (honoured only in IDLE)
//   op     in   [1:0] 00 add, 01 subtract, 10 multiply, 11 divide
//   a      in   [WIDTH-1:0] first operand / dividend
//   b      in   [WIDTH-1:0] second operand / divisor
//   busy   out  high in CALC and FINISH
//   done   out  one-cycle pulse in FINISH, result valid
//   result out  [2*WIDTH-1:0] operation result
//   flag   out  carry / borrow / overflow / error indicator
// ---------------------------------------------------------------------------
module seq_arithmetic #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               flag
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    logic               w_accept;
    logic               w_lastIter;
    logic               w_startsCalc;

    // Multiply and divide share the same working registers. For multiply,
    // {r_hi, r_lo} is the partial product and multiplier, and r_opnd is the
    // multiplicand. For divide, r_hi is the remainder, r_lo holds the
    // dividend/quotient, and r_opnd is the divisor.
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opnd;
    logic [CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0] r_result;
    logic               r_flag;

    logic [WIDTH:0]     w_addSum;
    logic [WIDTH:0]     w_subDiff;
    logic [WIDTH:0]     w_mulSum;
    logic [WIDTH-1:0]   w_mulHi;
    logic [WIDTH-1:0]   w_mulLo;
    logic [WIDTH-1:0]   w_iterHi;
    logic [WIDTH-1:0]   w_iterLo;
    logic               w_iterFlag;

    // Add and subtract are evaluated directly from the operands at the
    // accepting edge. Bit WIDTH of the difference is the borrow (a < b).
    assign w_addSum  = {1'b0, a} + {1'b0, b};
    assign w_subDiff = {1'b0, a} - {1'b0, b};

    // One shift-add step. Conditionally add the multiplicand into the
    // upper half, then shift the whole product right by one bit.
    assign w_mulSum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mulHi  = w_mulSum[WIDTH:1];
    assign w_mulLo  = {w_mulSum[0], r_lo[WIDTH-1:1]};

`ifdef SEQ_ARITHMETIC_DIV_EN
    logic               r_isDiv;
    logic [WIDTH:0]     w_divShift;
    logic               w_divGeq;
    logic [WIDTH-1:0]   w_divHi;
    logic [WIDTH-1:0]   w_divLo;

    // One restoring-division step. Shift the next dividend bit into the
    // remainder, and subtract the divisor only if it fits. A fit gives a
    // quotient bit of 1.
    assign w_divShift = {r_hi, r_lo[WIDTH-1]};
    assign w_divGeq   = (w_divShift >= {1'b0, r_opnd});
    assign w_divHi    = w_divGeq ? WIDTH'(w_divShift - {1'b0, r_opnd}) : w_divShift[WIDTH-1:0];
    assign w_divLo    = {r_lo[WIDTH-2:0], w_divGeq};

    assign w_iterHi     = r_isDiv ? w_divHi : w_mulHi;
    assign w_iterLo     = r_isDiv ? w_divLo : w_mulLo;
    assign w_iterFlag   = r_isDiv ? 1'b0 : (|w_mulHi);
    assign w_startsCalc = (op == 2'b10) || ((op == 2'b11) && (b != '0));
`else
    assign w_iterHi     = w_mulHi;
    assign w_iterLo     = w_mulLo;
    assign w_iterFlag   = |w_mulHi;
    assign w_startsCalc = (op == 2'b10);
`endif

    // State register. Reset returns to IDLE immediately and drops any
    // operation in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and handshake outputs. Start is honoured only in IDLE,
    // so a pulse during CALC or FINISH has no effect.
    always_comb begin
        w_stateNext = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        w_accept    = 1'b0;
        w_lastIter  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_stateNext = w_startsCalc ? CALC : FINISH;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (r_count == LAST_ITER) begin
                    w_lastIter  = 1'b1;
                    w_stateNext = FINISH;
                end
            end
            FINISH: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Datapath. Operands are captured only on acceptance. Single-cycle
    // results are written at that edge. Iterative results are written at
    // the edge of the final iteration, so result and flag hold their old
    // values throughout CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_flag   <= 1'b0;
`ifdef SEQ_ARITHMETIC_DIV_EN
            r_isDiv  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_count <= '0;
            case (op)
                2'b00: begin
                    r_result <= {{(WIDTH-1){1'b0}}, w_addSum};
                    r_flag   <= w_addSum[WIDTH];
                end
                2'b01: begin
                    r_result <= {{WIDTH{1'b0}}, w_subDiff[WIDTH-1:0]};
                    r_flag   <= w_subDiff[WIDTH];
                end
                2'b10: begin
                    r_hi    <= '0;
                    r_lo    <= b;
                    r_opnd  <= a;
`ifdef SEQ_ARITHMETIC_DIV_EN
                    r_isDiv <= 1'b0;
`endif
                end
                default: begin
`ifdef SEQ_ARITHMETIC_DIV_EN
                    if (b == '0) begin
                        r_result <= {a, {WIDTH{1'b1}}};
                        r_flag   <= 1'b1;
                    end else begin
                        r_hi    <= '0;
                        r_lo    <= a;
                        r_opnd  <= b;
                        r_isDiv <= 1'b1;
                    end
`else
                    r_result <= '0;
                    r_flag   <= 1'b1;
`endif
                end
            endcase
        end else if (r_state == CALC) begin
            r_hi    <= w_iterHi;
            r_lo    <= w_iterLo;
            r_count <= r_count + 1'b1;
            if (w_lastIter) begin
                r_result <= {w_iterHi, w_iterLo};
                r_flag   <= w_iterFlag;
            end
        end
    end

    assign result = r_result;
    assign flag   = r_flag;

endmodule

// File: tb/tb_seq_arithmetic.sv
// ---------------------------------------------------------------------------
// Testbench for seq_arithmetic (WIDTH=4).
//
// Directed vectors from the requirements are run first, then a reset
// abandoned mid-multiply, then randomized operations. Every operation is
// checked against an arithmetic reference model for result, flag and
// done latency. Divide expectations follow SEQ_ARITHMETIC_DIV_EN.
// ---------------------------------------------------------------------------
module tb_seq_arithmetic;

    localparam int W = 4;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [1:0]     op    = '0;
    logic [W-1:0]   a     = '0;
    logic [W-1:0]   b     = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           flag;

    int             checks = 0;
    int             errors = 0;

    logic [2*W-1:0] lastRes = '0;
    logic           lastFlg = 1'b0;

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    seq_arithmetic #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flag   (flag)
    );

    // Single comparison point. Counts every check, and reports and counts
    // every miss.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model computed with plain integer arithmetic. It returns
    // the expected result, flag, and the number of cycles from driving
    // start to seeing done.
    function automatic void refModel(input int o, input int x, input int y,
                                     output int res, output int flg, output int lat);
        int mask;
        mask = (1 << W) - 1;
        lat  = 1;
        res  = 0;
        flg  = 0;
        case (o)
            0: begin
                res = x + y;
                flg = (res >> W) & 1;
            end
            1: begin
                res = (x - y) & mask;
                flg = (x < y) ? 1 : 0;
            end
            2: begin
                res = x * y;
                flg = ((res >> W) != 0) ? 1 : 0;
                lat = W + 1;
            end
            default: begin
`ifdef SEQ_ARITHMETIC_DIV_EN
                if (y == 0) begin
                    res = (x << W) | mask;
                    flg = 1;
                end else begin
                    res = ((x % y) << W) | (x / y);
                    flg = 0;
                    lat = W + 1;
                end
`else
                res = 0;
                flg = 1;
`endif
            end
        endcase
    endfunction

    // Runs one operation. Call it at a negedge with the DUT idle, and it
    // returns at a negedge with the DUT idle again, so back-to-back calls
    // issue start in the cycle right after FINISH. Operands are scrambled
    // after acceptance to show they were latched. pulseMid re-asserts
    // start inside CALC, and that pulse must be ignored.
    task automatic applyStimulus(input string tag, input logic [1:0] o,
                                 input logic [W-1:0] x, input logic [W-1:0] y,
                                 input int expRes, input int expFlg,
                                 input int expLat, input bit pulseMid);
        int lat;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        lat   = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (lat == 2 && expLat > 2) begin
                checkOutput({tag, " busy-in-calc"}, 32'(busy), 32'd1);
                checkOutput({tag, " held-in-calc"}, 32'({flag, result}), 32'({lastFlg, lastRes}));
            end
            start = (pulseMid && lat == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checkOutput({tag, " latency"}, lat, expLat);
        checkOutput({tag, " result"}, 32'(result), expRes);
        checkOutput({tag, " flag"}, 32'(flag), expFlg);
        checkOutput({tag, " busy-at-done"}, 32'(busy), 32'd1);
        lastRes = (2*W)'(expRes);
        lastFlg = expFlg[0];
        @(negedge clk);
        checkOutput({tag, " done-pulse"}, 32'(done), 32'd0);
        checkOutput({tag, " idle-busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " result-held"}, 32'({flag, result}), 32'({lastFlg, lastRes}));
    endtask

    // Directed sequence followed by randomized operations.
    initial begin
        int res, flg, lat, doneSeen;
        logic [1:0] ro;
        logic [W-1:0] rx, ry;

        repeat (2) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset result", 32'(result), 32'd0);
        checkOutput("reset flag", 32'(flag), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus("add 9+8", 2'b00, 4'd9, 4'd8, 'h11, 1, 1, 1'b0);
        applyStimulus("sub 3-5", 2'b01, 4'd3, 4'd5, 'h0E, 1, 1, 1'b0);
        applyStimulus("sub 5-3", 2'b01, 4'd5, 4'd3, 'h02, 0, 1, 1'b0);
        applyStimulus("mul 15*15", 2'b10, 4'd15, 4'd15, 'hE1, 1, W + 1, 1'b1);
`ifdef SEQ_ARITHMETIC_DIV_EN
        applyStimulus("div 13/4", 2'b11, 4'd13, 4'd4, 'h13, 0, W + 1, 1'b0);
        applyStimulus("div 7/0", 2'b11, 4'd7, 4'd0, 'h7F, 1, 1, 1'b0);
`else
        applyStimulus("illegal 13/4", 2'b11, 4'd13, 4'd4, 'h00, 1, 1, 1'b0);
        applyStimulus("illegal 7/0", 2'b11, 4'd7, 4'd0, 'h00, 1, 1, 1'b0);
`endif

        // Reset two cycles into a multiply must clear everything at once
        // and never produce a done pulse.
        op    = 2'b10;
        a     = 4'd15;
        b     = 4'd15;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset done", 32'(done), 32'd0);
        checkOutput("midreset result", 32'(result), 32'd0);
        checkOutput("midreset flag", 32'(flag), 32'd0);
        doneSeen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) doneSeen++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) doneSeen++;
        end
        checkOutput("midreset no-done", doneSeen, 0);
        lastRes = '0;
        lastFlg = 1'b0;
        applyStimulus("add 1+1 after reset", 2'b00, 4'd1, 4'd1, 'h02, 0, 1, 1'b0);

        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = W'($urandom_range(0, 15));
            ry = ($urandom_range(0, 6) == 0) ? '0 : W'($urandom_range(0, 15));
            refModel(int'(ro), int'(rx), int'(ry), res, flg, lat);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            applyStimulus($sformatf("rand%0d op%0d %0d,%0d", i, ro, rx, ry),
                          ro, rx, ry, res, flg, lat, $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_arithmetic.md
SEQ_ARITHMETIC -- requirements
Module: seq_arithmetic

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin an operation.
REQ-005 SHALL have port op, input, 2, operation select: 00 add, 01 subtract, 10 multiply, 11 divide.
REQ-006 SHALL have port a, input, WIDTH, first operand (unsigned; dividend for divide).
REQ-007 SHALL have port b, input, WIDTH, second operand (unsigned; divisor for divide).
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking result valid.
REQ-010 SHALL have port result, output, 2*WIDTH, operation result.
REQ-011 SHALL have port flag, output, 1, carry/borrow/overflow/error indicator.

Function
REQ-012 SHALL implement states IDLE, CALC, FINISH; busy=1 in CALC and FINISH only.
REQ-013 SHALL accept start only in IDLE; on acceptance latch a, b and op, then ignore later changes on a, b and op.
REQ-014 SHALL ignore start asserted while busy=1, with no effect on the operation in progress.
REQ-015 SHALL, for add and subtract, go IDLE->FINISH and assert done in the cycle after the accepting edge (latency 1).
REQ-016 SHALL, for multiply and divide (nonzero b), go IDLE->CALC, perform exactly WIDTH iterations, then go to FINISH; done asserts WIDTH+1 cycles after the accepting edge.
REQ-017 SHALL return FINISH->IDLE after one cycle; done SHALL be high only in FINISH.
REQ-018 SHALL produce add result = zero-extended (a+b) in WIDTH+1 bits, with flag = carry-out bit WIDTH.
REQ-019 SHALL produce subtract result = (a-b) mod 2^WIDTH in the low WIDTH bits with upper bits 0, and flag = borrow (a<b).
REQ-020 SHALL compute multiply by iterative shift-add giving result = a*b in 2*WIDTH bits, with flag = 1 if the upper WIDTH bits are nonzero.
REQ-021 SHALL compute divide by restoring division giving result = {remainder, quotient}, each WIDTH bits, with flag = 0.
REQ-022 SHALL, when dividing by b=0, skip CALC and finish at latency 1 with quotient all-ones, remainder = a, and flag = 1.
REQ-023 SHALL hold result and flag stable from FINISH until the next accepted start, and SHALL not update them during CALC.
REQ-024 SHALL accept a start arriving in the cycle after FINISH (back-to-back operation).

Reset
REQ-025 SHALL, on rst_n low, immediately force state IDLE, busy=0, done=0, result=0, flag=0, and clear internal iteration registers.
REQ-026 SHALL, if reset asserts mid-CALC, abandon the operation with no done pulse; the first start after release SHALL run normally.

Configuration
REQ-027 SHALL include the divider datapath only when macro SEQ_ARITHMETIC_DIV_EN is defined.
REQ-028 SHALL, without SEQ_ARITHMETIC_DIV_EN, treat op=11 as illegal: latency 1, result=0, flag=1; add, subtract and multiply SHALL be unchanged.

Verification (WIDTH=4)
REQ-029 SHALL cover: add a=9, b=8 -> done 1 cycle after start, result=0x11, flag=1.
REQ-030 SHALL cover: sub a=3, b=5 -> result=0x0E, flag=1; sub a=5, b=3 -> result=0x02, flag=0.
REQ-031 SHALL cover: mul a=15, b=15 -> done 5 cycles after start, result=0xE1, flag=1; start pulsed mid-CALC ignored.
REQ-032 SHALL cover: div a=13, b=4 -> done 5 cycles after start, result=0x13, flag=0; div a=7, b=0 -> done 1 cycle after start, result=0x7F, flag=1.
REQ-033 SHALL cover: rst_n low 2 cycles into mul -> busy=0, result=0 immediately, no done pulse; next add 1+1 -> result=0x02.
REQ-034 SHALL cover: build without SEQ_ARITHMETIC_DIV_EN, div a=13, b=4 -> done 1 cycle after start, result=0x00, flag=1.
